// File: rtl/tmu2_fdest_mc_if.sv
// Signal bundle between the destination fetch cache, the TMU2 pipeline and the FML bus.
// The slave modport is the cache; the master modport is its surroundings.
interface tmu2_fdest_mc_if #(
  parameter int fml_depth = 26
);
  logic [fml_depth-1:0] fml_adr;
  logic                 fml_stb;
  logic                 fml_ack;
  logic [63:0]          fml_di;
  logic                 flush;
  logic                 busy;
  logic                 fetch_en;
  logic                 pipe_stb_i;
  logic                 pipe_ack_o;
  logic [15:0]          color;
  logic [fml_depth-2:0] dadr;
  logic                 pipe_stb_o;
  logic                 pipe_ack_i;
  logic [15:0]          color_f;
  logic [fml_depth-2:0] dadr_f;
  logic [15:0]          dcolor;
  logic [31:0]          miss_count;

  modport slave (
    input  fml_ack, fml_di, flush, fetch_en, pipe_stb_i, color, dadr, pipe_ack_i,
    output fml_adr, fml_stb, busy, pipe_ack_o, pipe_stb_o, color_f, dadr_f, dcolor, miss_count
  );

  modport master (
    output fml_ack, fml_di, flush, fetch_en, pipe_stb_i, color, dadr, pipe_ack_i,
    input  fml_adr, fml_stb, busy, pipe_ack_o, pipe_stb_o, color_f, dadr_f, dcolor, miss_count
  );
endinterface

// File: rtl/tmu2_fdest_mc.sv
// Direct-mapped destination pixel cache: one 4x64-bit FML burst per line, 2^line_bits lines.
// state   | meaning
// IDLE    | pass pixels through; start a fill on a miss
// FETCH1  | burst requested, waiting for fml_ack (beat 0 captured every cycle)
// FETCH2-4| capture beats 1..3; FETCH4 also commits tag and valid
// OUT     | present the filled pixel downstream until acknowledged
module tmu2_fdest_mc #(
  parameter int fml_depth = 26,
  parameter int line_bits = 2
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  tmu2_fdest_mc_if.slave  bus
);
  localparam int AW    = fml_depth - 1;
  localparam int IDXW  = (line_bits > 0) ? line_bits : 1;
  localparam int TAGW  = fml_depth - 5 - line_bits;
  localparam int NLINE = 1 << IDXW;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4, S_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     dadr_q;
  logic [15:0]       color_q;
  logic              hit_q;
  logic              wanted_q;
  logic [31:0]       miss_q;
  logic [NLINE-1:0]  valid_q;
  logic [TAGW-1:0]   tag_mem [NLINE];
  logic [63:0]       data_mem [NLINE*4];

  logic [IDXW-1:0]   idx_in, idx_r;
  logic [TAGW-1:0]   tag_in, tag_r;
  logic              accept, lookup_hit;
  logic              ack_o, stb_o, fml_stb_o;
  logic              mem_we, fill_done, miss_inc;
  logic [1:0]        mem_beat;
  logic [63:0]       rd_beat;

  // A single-line cache has no index bits; every address maps to line 0.
  if (line_bits == 0) begin : g_one_line
    assign idx_in = '0;
    assign idx_r  = '0;
  end else begin : g_multi_line
    assign idx_in = bus.dadr[4 +: IDXW];
    assign idx_r  = dadr_q[4 +: IDXW];
  end

  assign tag_in     = bus.dadr[AW-1 -: TAGW];
  assign tag_r      = dadr_q[AW-1 -: TAGW];
  assign lookup_hit = valid_q[idx_in] & (tag_mem[idx_in] == tag_in);
  assign accept     = bus.pipe_stb_i & ack_o;

  always_comb begin
    state_d   = state_q;
    ack_o     = 1'b0;
    stb_o     = 1'b0;
    fml_stb_o = 1'b0;
    mem_we    = 1'b0;
    mem_beat  = 2'd0;
    fill_done = 1'b0;
    miss_inc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ack_o = bus.pipe_ack_i | ~wanted_q;
        stb_o = wanted_q & (hit_q | ~bus.fetch_en);
        if (wanted_q & ~hit_q & bus.fetch_en) begin
          ack_o    = 1'b0;
          miss_inc = 1'b1;
          state_d  = S_FETCH1;
        end
      end
      S_FETCH1: begin
        fml_stb_o = 1'b1;
        mem_we    = 1'b1;
        if (bus.fml_ack) state_d = S_FETCH2;
      end
      S_FETCH2: begin
        mem_we   = 1'b1;
        mem_beat = 2'd1;
        state_d  = S_FETCH3;
      end
      S_FETCH3: begin
        mem_we   = 1'b1;
        mem_beat = 2'd2;
        state_d  = S_FETCH4;
      end
      S_FETCH4: begin
        mem_we    = 1'b1;
        mem_beat  = 2'd3;
        fill_done = 1'b1;
        state_d   = S_OUT;
      end
      S_OUT: begin
        stb_o = 1'b1;
        ack_o = bus.pipe_ack_i;
        if (bus.pipe_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      valid_q  <= '0;
      hit_q    <= 1'b0;
      wanted_q <= 1'b0;
      dadr_q   <= '0;
      color_q  <= '0;
      miss_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ack_o) wanted_q <= bus.pipe_stb_i;
      if (accept) begin
        dadr_q  <= bus.dadr;
        color_q <= bus.color;
        hit_q   <= lookup_hit;
      end
      if (miss_inc) miss_q <= miss_q + 32'd1;
      // Flush overrides both a fresh lookup and a fill completing in the same cycle.
      if (bus.flush) begin
        valid_q <= '0;
        hit_q   <= 1'b0;
      end else if (fill_done) begin
        valid_q[idx_r] <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (mem_we) data_mem[{idx_r, mem_beat}] <= bus.fml_di;
    if (fill_done) tag_mem[idx_r] <= tag_r;
  end

  assign rd_beat = data_mem[{idx_r, dadr_q[3:2]}];

  always_comb begin
    unique case (dadr_q[1:0])
      2'd0:    bus.dcolor = rd_beat[63:48];
      2'd1:    bus.dcolor = rd_beat[47:32];
      2'd2:    bus.dcolor = rd_beat[31:16];
      default: bus.dcolor = rd_beat[15:0];
    endcase
  end

  assign bus.fml_adr    = {dadr_q[AW-1:4], 5'd0};
  assign bus.fml_stb    = fml_stb_o;
  assign bus.pipe_ack_o = ack_o;
  assign bus.pipe_stb_o = stb_o;
  assign bus.busy       = wanted_q;
  assign bus.color_f    = color_q;
  assign bus.dadr_f     = dadr_q;
  assign bus.miss_count = miss_q;
endmodule
